// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution stream controller.
// Holds the controller state encoding and default image dimensions.
package conv_pkg;

    // Default image geometry (pixels per row, rows per frame).
    localparam int DEF_N = 32;
    localparam int DEF_H = 32;

    // Width of the optional stall counter.
    localparam int STALL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/conv_pos_counter.sv
// Raster position counter: col runs 0..N-1, row advances on col wrap.
// Ports: clk, rst (sync, active-high), clr (restart at 0,0), inc (advance one
// pixel); row, col (current position), last (position is H-1,N-1).
module conv_pos_counter
    import conv_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int H = DEF_H
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [$clog2(H)-1:0] row,
    output logic [$clog2(N)-1:0] col,
    output logic                 last
);

    localparam int RW = $clog2(H);
    localparam int CW = $clog2(N);

    localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(N - 1);

    logic col_wrap;
    logic row_wrap;

    assign col_wrap = (col == COL_MAX);
    assign row_wrap = (row == ROW_MAX);
    assign last     = col_wrap && row_wrap;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col_wrap) begin
                col <= '0;
                row <= row_wrap ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_stream_ctrl.sv
// Streams a raster frame into a 3x3 window cache and flags complete windows.
// Ports: clk, rst (sync, active-high), start; in_valid/in_data/in_ready
// (pixel input handshake); cache_load/cache_data (window cache write);
// win_valid/out_ready (window output handshake); win_row/win_col (window
// centre); busy, done (frame status). Optional macro CONV_CTRL_STALL_CNT_EN
// adds stall_cnt (saturating count of RUN cycles with in_valid && !in_ready).
module conv_stream_ctrl
    import conv_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int H = DEF_H
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 cache_load,
    output logic [7:0]           cache_data,
    output logic                 win_valid,
    input  logic                 out_ready,
    output logic [$clog2(H)-1:0] win_row,
    output logic [$clog2(N)-1:0] win_col,
    output logic                 busy,
    output logic                 done
`ifdef CONV_CTRL_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0]   stall_cnt
`endif
);

    localparam int RW = $clog2(H);
    localparam int CW = $clog2(N);

    localparam logic [RW-1:0] ROW_MIN = RW'(2);
    localparam logic [CW-1:0] COL_MIN = CW'(2);

    state_t state;
    state_t state_nxt;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          last;

    logic run_entry;
    logic accept;
    logic qual;
    logic win_take;

    // Counters restart at the same moment the FSM leaves IDLE.
    assign run_entry = (state == ST_IDLE) && start;

    // The cache must not be overwritten while an unconsumed window sits in it.
    assign in_ready = !rst
                   && (state == ST_RUN)
                   && (!win_valid || out_ready);

    assign accept     = in_valid && in_ready;
    assign cache_load = accept;
    assign cache_data = in_data;

    // Only a pixel at row>=2, col>=2 closes a window lying entirely in
    // three consecutive rows without crossing a row wrap.
    assign qual     = accept && (row >= ROW_MIN) && (col >= COL_MIN);
    assign win_take = win_valid && out_ready;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    conv_pos_counter #(
        .N (N),
        .H (H)
    ) u_pos (
        .clk  (clk),
        .rst  (rst),
        .clr  (run_entry),
        .inc  (accept),
        .row  (row),
        .col  (col),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && last) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!win_valid || out_ready) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // A new qualifying pixel wins over a handshake in the same cycle,
    // so back-to-back windows keep win_valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (qual) begin
            win_valid <= 1'b1;
            win_row   <= row - 1'b1;
            win_col   <= col - 1'b1;
        end else if (win_take) begin
            win_valid <= 1'b0;
        end
    end

`ifdef CONV_CTRL_STALL_CNT_EN
    logic stall;

    assign stall = (state == ST_RUN) && in_valid && !in_ready;

    always_ff @(posedge clk) begin
        if (rst || run_entry) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Directed bench for conv_stream_ctrl with N=4, H=4.
// Define CONV_CTRL_STALL_CNT_EN to also exercise the stall counter.
module tb_conv_stream_ctrl;

    localparam int N = 4;
    localparam int H = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       cache_load;
    logic [7:0] cache_data;
    logic       win_valid;
    logic       out_ready;
    logic [1:0] win_row;
    logic [1:0] win_col;
    logic       busy;
    logic       done;
`ifdef CONV_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [3:0] wq[$];

    conv_stream_ctrl #(
        .N (N),
        .H (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cache_load (cache_load),
        .cache_data (cache_data),
        .win_valid  (win_valid),
        .out_ready  (out_ready),
        .win_row    (win_row),
        .win_col    (win_col),
        .busy       (busy),
        .done       (done)
`ifdef CONV_CTRL_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every consumed window and every done cycle mid-period.
    always @(negedge clk) begin
        if (!rst) begin
            if (win_valid && out_ready) begin
                wq.push_back({win_row, win_col});
            end
            if (done) begin
                done_cnt = done_cnt + 1;
            end
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full frame of 16 pixels. toggle: in_valid 1/0 alternating.
    // restart_at: pulse start alongside that pixel. stall_at: hold
    // out_ready low 5 cycles after that pixel is accepted.
    task automatic frame(input bit toggle,
                         input int restart_at,
                         input int stall_at);
        int r;
        int c;
        int p;
        int cyc;
        bit acc;
        bit ewv;
        logic [1:0] er;
        logic [1:0] ec;
        wq.delete();
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_run", busy, 1);
        r = 0; c = 0; p = 1; cyc = 0;
        ewv = 0; er = 0; ec = 0;
        while (p <= 16) begin
            in_valid  = toggle ? (cyc % 2 == 0) : 1'b1;
            in_data   = p[7:0];
            out_ready = 1'b1;
            start     = (p == restart_at);
            #1;
            acc = in_valid;
            check("in_ready", in_ready, 1);
            check("cache_load", cache_load, acc);
            if (acc) check("cache_data", cache_data, p);
            @(posedge clk); #1;
            start = 1'b0;
            if (acc && r >= 2 && c >= 2) begin
                ewv = 1;
                er  = 2'(r - 1);
                ec  = 2'(c - 1);
            end else begin
                ewv = 0;
            end
            check("win_valid", win_valid, ewv);
            if (ewv) begin
                check("win_row", win_row, er);
                check("win_col", win_col, ec);
            end
            cyc = cyc + 1;
            if (acc) begin
                p = p + 1;
                c = c + 1;
                if (c == N) begin
                    c = 0;
                    r = r + 1;
                end
                if (p - 1 == stall_at) begin
                    out_ready = 1'b0;
                    in_valid  = 1'b1;
                    in_data   = p[7:0];
                    for (int k = 0; k < 5; k++) begin
                        #1;
                        check("stall_in_ready", in_ready, 0);
                        check("stall_cache_load", cache_load, 0);
                        @(posedge clk); #1;
                        check("stall_win_valid", win_valid, 1);
                        check("stall_win_row", win_row, er);
                        check("stall_win_col", win_col, ec);
                    end
`ifdef CONV_CTRL_STALL_CNT_EN
                    check("stall_cnt", stall_cnt, 5);
`endif
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("flush_busy", busy, 1);
        @(posedge clk); #1;
        check("done_high", done, 1);
        check("done_win_valid", win_valid, 0);
        @(posedge clk); #1;
        check("done_low", done, 0);
        check("busy_end", busy, 0);
        check("win_count", wq.size(), 4);
        check("done_count", done_cnt, 1);
        if (wq.size() == 4) begin
            check("win0", wq[0], 4'h5);
            check("win1", wq[1], 4'h6);
            check("win2", wq[2], 4'h9);
            check("win3", wq[3], 4'hA);
        end
    endtask

    // Start a frame, feed n pixels, then reset mid-frame.
    task automatic abort(input int n);
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= n; i++) begin
            in_data = i[7:0];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_win_valid", win_valid, 0);
        check("abort_win_row", win_row, 0);
        check("abort_win_col", win_col, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_done", done, 0);
        in_valid = 1'b1;
        #1;
        check("abort_cache_load", cache_load, 0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_done_count", done_cnt, 0);
        check("abort_idle", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_cache_load", cache_load, 0);
        check("rst_win_row", win_row, 0);
        check("rst_win_col", win_col, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_hold", busy, 0);

        frame(1'b0, 0, 0);
        frame(1'b0, 0, 11);
        abort(7);
        frame(1'b0, 0, 0);
        abort(11);
        frame(1'b0, 5, 0);
        frame(1'b1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
